// File: rtl/clock_input_conditioner.sv
// -----------------------------------------------------------------------------
// clock_input_conditioner
//
// Front end of the D2 clock. Turns the 200 Hz system clock and two raw,
// active-low, bouncy set buttons into clean one-cycle strobes for the display
// sequencer:
//   - a minute prescaler producing Tick once every TICK_DIV cycles
//   - per button: two-flop synchroniser, debounce, press-and-hold auto-repeat
//   - minute-set arbitration: a minute-button pulse restarts the prescaler and
//     suppresses a Tick that would coincide with it, so Tick and SyncMinOut are
//     never high together and no increment is lost downstream.
//
// Ports (top):
//   Clock        in   system clock, all state on the rising edge
//   nReset       in   asynchronous active-low reset
//   nMinBtn      in   raw minute-set button, low = pressed, asynchronous
//   nHourBtn     in   raw hour-set button, low = pressed, asynchronous
//   Tick         out  one-cycle strobe, once per minute
//   SyncMinOut   out  one-cycle strobe, increment minutes
//   SyncHourOut  out  one-cycle strobe, increment hours
//
// clock_input_conditioner_btn (helper, one per button):
//   clk, rst_n   clock and asynchronous active-low reset
//   btn_n        raw button pin, low = pressed
//   fire         combinational: a strobe is due on the coming edge
// -----------------------------------------------------------------------------

module clock_input_conditioner_btn #(
    parameter int unsigned DEBOUNCE      = 4,
    parameter int unsigned REPEAT_DELAY  = 100,
    parameter int unsigned REPEAT_PERIOD = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic fire
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE - 1);
    localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    logic              sync_1;
    logic              sync_2;
    logic              stable;      // debounced level, 1 = released
    logic [DB_W-1:0]   db_cnt;
    logic              flip;
    logic              press_ev;
    logic              release_ev;
    state_t            state;
    logic [RPT_W-1:0]  rpt_cnt;

    // The edge on which the counter would reach DEBOUNCE is the edge on which
    // the debounced level flips; exposing it combinationally lets the button
    // FSM act on that same edge.
    assign flip       = (sync_2 != stable) && (db_cnt == DB_LAST);
    assign press_ev   = flip & ~sync_2;
    assign release_ev = flip &  sync_2;

    // Synchroniser and debounce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            stable <= 1'b1;
            db_cnt <= '0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
            if (sync_2 == stable) begin
                db_cnt <= '0;
            end else if (flip) begin
                stable <= sync_2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // A release always wins, even over a repeat pulse due on the same edge.
    always_comb begin
        fire = 1'b0;
        if (!release_ev) begin
            case (state)
                IDLE:          fire = press_ev;
                DELAY, REPEAT: fire = (rpt_cnt == '0);
                default:       fire = 1'b0;
            endcase
        end
    end

    // Press-and-hold auto-repeat FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rpt_cnt <= '0;
        end else if (release_ev) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (press_ev) begin
                        rpt_cnt <= DELAY_LOAD;
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    if (rpt_cnt == '0) begin
                        rpt_cnt <= PERIOD_LOAD;
                        state   <= REPEAT;
                    end else begin
                        rpt_cnt <= rpt_cnt - RPT_W'(1);
                    end
                end
                REPEAT: begin
                    if (rpt_cnt == '0) begin
                        rpt_cnt <= PERIOD_LOAD;
                    end else begin
                        rpt_cnt <= rpt_cnt - RPT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

module clock_input_conditioner #(
    parameter int unsigned TICK_DIV      = 12000,
    parameter int unsigned DEBOUNCE      = 4,
    parameter int unsigned REPEAT_DELAY  = 100,
    parameter int unsigned REPEAT_PERIOD = 40
) (
    input  logic Clock,
    input  logic nReset,
    input  logic nMinBtn,
    input  logic nHourBtn,
    output logic Tick,
    output logic SyncMinOut,
    output logic SyncHourOut
);

    localparam int unsigned PS_W = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic            min_fire;
    logic            hour_fire;
    logic [PS_W-1:0] presc;

    clock_input_conditioner_btn #(
        .DEBOUNCE      (DEBOUNCE),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_min_btn (
        .clk   (Clock),
        .rst_n (nReset),
        .btn_n (nMinBtn),
        .fire  (min_fire)
    );

    clock_input_conditioner_btn #(
        .DEBOUNCE      (DEBOUNCE),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_hour_btn (
        .clk   (Clock),
        .rst_n (nReset),
        .btn_n (nHourBtn),
        .fire  (hour_fire)
    );

    // Output stage and prescaler. The button strobes are registered here
    // rather than inside the helper so that the minute strobe and the
    // prescaler restart share the same edge.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            presc       <= '0;
            Tick        <= 1'b0;
            SyncMinOut  <= 1'b0;
            SyncHourOut <= 1'b0;
        end else begin
            SyncMinOut  <= min_fire;
            SyncHourOut <= hour_fire;
            if (min_fire) begin
                // Setting minutes restarts the seconds; a wrap on this edge
                // is dropped so Tick never overlaps SyncMinOut.
                presc <= '0;
                Tick  <= 1'b0;
            end else if (presc == PS_LAST) begin
                presc <= '0;
                Tick  <= 1'b1;
            end else begin
                presc <= presc + PS_W'(1);
                Tick  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_clock_input_conditioner
//
// Bench for clock_input_conditioner with a short prescaler (TICK_DIV = 10) and
// default debounce / repeat timing. Each scenario pushes the edge numbers on
// which strobes are expected into queues; a negedge monitor pops and compares
// them as strobes appear.
// -----------------------------------------------------------------------------

module tb_clock_input_conditioner;

    localparam int TB_TICK = 10;
    localparam int TB_DB   = 4;
    localparam int TB_RD   = 100;
    localparam int TB_RP   = 40;
    localparam int LAT     = TB_DB + 2;

    logic Clock;
    logic nReset;
    logic nMinBtn;
    logic nHourBtn;
    logic Tick;
    logic SyncMinOut;
    logic SyncHourOut;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rel   = 0;
    int mon_e;
    bit chk_tick = 1'b0;

    int exp_min[$];
    int exp_hour[$];
    int exp_tick[$];

    clock_input_conditioner #(
        .TICK_DIV      (TB_TICK),
        .DEBOUNCE      (TB_DB),
        .REPEAT_DELAY  (TB_RD),
        .REPEAT_PERIOD (TB_RP)
    ) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .nMinBtn     (nMinBtn),
        .nHourBtn    (nHourBtn),
        .Tick        (Tick),
        .SyncMinOut  (SyncMinOut),
        .SyncHourOut (SyncHourOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Scoreboard monitor: value of cyc at a negedge is the number of the
    // rising edge that produced the current output cycle.
    always @(negedge Clock) begin
        if (SyncMinOut === 1'b1) begin
            tests++;
            if (exp_min.size() == 0) begin
                fails++;
                $display("FAIL min_pulse: unexpected pulse at edge %0d, expected none", cyc);
            end else begin
                mon_e = exp_min.pop_front();
                if (cyc !== mon_e) begin
                    fails++;
                    $display("FAIL min_pulse: pulse at edge %0d, expected edge %0d", cyc, mon_e);
                end
            end
            tests++;
            if (Tick !== 1'b0) begin
                fails++;
                $display("FAIL tick_min_overlap: Tick=%b with SyncMinOut at edge %0d, expected 0", Tick, cyc);
            end
        end
        if (SyncHourOut === 1'b1) begin
            tests++;
            if (exp_hour.size() == 0) begin
                fails++;
                $display("FAIL hour_pulse: unexpected pulse at edge %0d, expected none", cyc);
            end else begin
                mon_e = exp_hour.pop_front();
                if (cyc !== mon_e) begin
                    fails++;
                    $display("FAIL hour_pulse: pulse at edge %0d, expected edge %0d", cyc, mon_e);
                end
            end
        end
        if (chk_tick && Tick === 1'b1) begin
            tests++;
            if (exp_tick.size() == 0) begin
                fails++;
                $display("FAIL tick: unexpected Tick at edge %0d, expected none", cyc);
            end else begin
                mon_e = exp_tick.pop_front();
                if (cyc !== mon_e) begin
                    fails++;
                    $display("FAIL tick: Tick at edge %0d, expected edge %0d", cyc, mon_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge Clock);
    endtask

    task automatic do_reset();
        nMinBtn  = 1'b1;
        nHourBtn = 1'b1;
        @(negedge Clock);
        #2 nReset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        rel = cyc;
    endtask

    task automatic test_reset();
        nReset   = 1'b1;
        nMinBtn  = 1'b1;
        nHourBtn = 1'b1;
        #2 nReset = 1'b0;
        #1;
        tests++;
        if ({Tick, SyncMinOut, SyncHourOut} !== 3'b000) begin
            fails++;
            $display("FAIL reset_async: outputs %b, expected 000", {Tick, SyncMinOut, SyncHourOut});
        end
        repeat (3) @(negedge Clock);
        tests++;
        if ({Tick, SyncMinOut, SyncHourOut} !== 3'b000) begin
            fails++;
            $display("FAIL reset_held: outputs %b, expected 000", {Tick, SyncMinOut, SyncHourOut});
        end
        nReset = 1'b1;
        @(negedge Clock);
        tests++;
        if ({Tick, SyncMinOut, SyncHourOut} !== 3'b000) begin
            fails++;
            $display("FAIL reset_release: outputs %b, expected 000", {Tick, SyncMinOut, SyncHourOut});
        end
    endtask

    task automatic test_tick();
        do_reset();
        exp_tick.push_back(rel + TB_TICK);
        exp_tick.push_back(rel + 2 * TB_TICK);
        exp_tick.push_back(rel + 3 * TB_TICK);
        chk_tick = 1'b1;
        wait_cyc(rel + 3 * TB_TICK + 5);
        chk_tick = 1'b0;
        tests++;
        if (exp_tick.size() + exp_min.size() + exp_hour.size() != 0) begin
            fails++;
            $display("FAIL tick_pending: %0d events missing, expected 0",
                     exp_tick.size() + exp_min.size() + exp_hour.size());
        end
        exp_tick.delete(); exp_min.delete(); exp_hour.delete();
    endtask

    task automatic test_bounce();
        int c;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            nMinBtn = 1'b0;
            repeat (3) @(negedge Clock);
            nMinBtn = 1'b1;
            @(negedge Clock);
        end
        c = cyc;
        nMinBtn = 1'b0;
        exp_min.push_back(c + LAT);
        wait_cyc(c + 30);
        nMinBtn = 1'b1;
        wait_cyc(c + 45);
        tests++;
        if (exp_min.size() + exp_hour.size() != 0) begin
            fails++;
            $display("FAIL bounce_pending: %0d pulses missing, expected 0", exp_min.size() + exp_hour.size());
        end
        exp_min.delete(); exp_hour.delete();
    endtask

    task automatic test_auto_repeat();
        int c;
        int t0;
        do_reset();
        c = cyc;
        nHourBtn = 1'b0;
        t0 = c + LAT;
        exp_hour.push_back(t0);
        for (int k = 0; k < 5; k++) exp_hour.push_back(t0 + TB_RD + k * TB_RP);
        wait_cyc(c + 300);
        nHourBtn = 1'b1;
        wait_cyc(c + 340);
        tests++;
        if (exp_min.size() + exp_hour.size() != 0) begin
            fails++;
            $display("FAIL repeat_pending: %0d pulses missing, expected 0", exp_min.size() + exp_hour.size());
        end
        exp_min.delete(); exp_hour.delete();
    endtask

    task automatic test_tick_collision();
        int c;
        do_reset();
        chk_tick = 1'b1;
        exp_tick.push_back(rel + TB_TICK);
        // Minute pulse lands on the second prescaler wrap edge.
        c = rel + 2 * TB_TICK - LAT;
        exp_min.push_back(rel + 2 * TB_TICK);
        exp_tick.push_back(rel + 3 * TB_TICK);
        exp_tick.push_back(rel + 4 * TB_TICK);
        exp_tick.push_back(rel + 5 * TB_TICK);
        wait_cyc(c);
        nMinBtn = 1'b0;
        wait_cyc(c + 20);
        nMinBtn = 1'b1;
        wait_cyc(rel + 5 * TB_TICK + 5);
        chk_tick = 1'b0;
        tests++;
        if (exp_tick.size() + exp_min.size() + exp_hour.size() != 0) begin
            fails++;
            $display("FAIL collision_pending: %0d events missing, expected 0",
                     exp_tick.size() + exp_min.size() + exp_hour.size());
        end
        exp_tick.delete(); exp_min.delete(); exp_hour.delete();
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        c = cyc;
        nMinBtn  = 1'b0;
        nHourBtn = 1'b0;
        exp_min.push_back(c + LAT);
        exp_hour.push_back(c + LAT);
        exp_min.push_back(c + LAT + TB_RD);
        exp_hour.push_back(c + LAT + TB_RD);
        exp_min.push_back(c + LAT + TB_RD + TB_RP);
        exp_hour.push_back(c + LAT + TB_RD + TB_RP);
        wait_cyc(c + 160);
        nMinBtn  = 1'b1;
        nHourBtn = 1'b1;
        wait_cyc(c + 200);
        tests++;
        if (exp_min.size() + exp_hour.size() != 0) begin
            fails++;
            $display("FAIL lockstep_pending: %0d pulses missing, expected 0", exp_min.size() + exp_hour.size());
        end
        exp_min.delete(); exp_hour.delete();
    endtask

    task automatic test_reset_mid_hold();
        int c;
        int r;
        do_reset();
        c = cyc;
        nMinBtn = 1'b0;
        exp_min.push_back(c + LAT);
        exp_min.push_back(c + LAT + TB_RD);
        exp_min.push_back(c + LAT + TB_RD + TB_RP);
        wait_cyc(c + LAT + TB_RD + TB_RP);
        // SyncMinOut is high in this cycle; reset must drop it at once.
        #2 nReset = 1'b0;
        #1;
        tests++;
        if ({Tick, SyncMinOut, SyncHourOut} !== 3'b000) begin
            fails++;
            $display("FAIL midhold_async: outputs %b, expected 000", {Tick, SyncMinOut, SyncHourOut});
        end
        @(negedge Clock);
        tests++;
        if ({Tick, SyncMinOut, SyncHourOut} !== 3'b000) begin
            fails++;
            $display("FAIL midhold_reset: outputs %b, expected 000", {Tick, SyncMinOut, SyncHourOut});
        end
        @(negedge Clock);
        nReset = 1'b1;
        r = cyc;
        exp_min.push_back(r + LAT);
        exp_min.push_back(r + LAT + TB_RD);
        wait_cyc(r + LAT + TB_RD + 4);
        nMinBtn = 1'b1;
        wait_cyc(r + LAT + TB_RD + 30);
        tests++;
        if (exp_min.size() + exp_hour.size() != 0) begin
            fails++;
            $display("FAIL midhold_pending: %0d pulses missing, expected 0", exp_min.size() + exp_hour.size());
        end
        exp_min.delete(); exp_hour.delete();
    endtask

    initial begin
        test_reset();
        test_tick();
        test_bounce();
        test_auto_repeat();
        test_tick_collision();
        test_back_to_back();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
